// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Shared binary32 field widths, special constants and decode
//             helpers for the floating-point accumulator slice.
//  Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int          EXP_W   = 8;
    localparam int          MAN_W   = 23;
    localparam int          BIAS    = 127;
    localparam int          FP_W    = 32;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    // Exponent all ones with a non-zero fraction.
    function automatic logic is_nan(input logic [FP_W-1:0] x);
        return (&x[FP_W-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

    // Exponent all ones with a zero fraction (either sign).
    function automatic logic is_inf(input logic [FP_W-1:0] x);
        return (&x[FP_W-2:MAN_W]) && !(|x[MAN_W-1:0]);
    endfunction

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_adder.sv
`default_nettype none
// ============================================================================
//  Module   : fp_adder
//  Purpose  : Combinational binary32 adder, round-to-nearest-even, with
//             subnormal support. Any NaN operand or inf-inf gives QNAN.
//  Ports    : a, b - operands;  s - rounded sum
//  Revision : 1.0  initial release
// ============================================================================
module fp_adder
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] s
);

    logic        w_swap;
    logic        w_same;
    logic [31:0] w_x;          // operand with the larger magnitude
    logic [31:0] w_y;
    logic [7:0]  w_ex;
    logic [7:0]  w_ey;
    logic [7:0]  w_d;
    logic [26:0] w_my_ext;     // hidden bit, 23-bit fraction, guard/round/sticky
    logic [26:0] w_mask;
    logic [26:0] w_aligned;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [9:0]  w_e;
    logic [9:0]  w_l;
    logic [26:0] w_m;
    logic        w_rnd;
    logic [24:0] w_mr;
    logic [9:0]  w_ef;

    always_comb begin
        w_swap    = (b[30:0] > a[30:0]);
        w_x       = w_swap ? b : a;
        w_y       = w_swap ? a : b;
        w_same    = (w_x[31] == w_y[31]);
        // Subnormals use an effective exponent of 1.
        w_ex      = (w_x[30:23] == 8'd0) ? 8'd1 : w_x[30:23];
        w_ey      = (w_y[30:23] == 8'd0) ? 8'd1 : w_y[30:23];
        w_d       = w_ex - w_ey;
        w_my_ext  = {(w_y[30:23] != 8'd0), w_y[22:0], 3'b000};
        // Bits shifted out of the smaller operand collapse into the sticky LSB.
        w_mask    = ~({27{1'b1}} << w_d);
        w_aligned = (w_my_ext >> w_d) | {26'd0, |(w_my_ext & w_mask)};
        if (w_same)
            w_sum = {1'b0, (w_x[30:23] != 8'd0), w_x[22:0], 3'b000} + {1'b0, w_aligned};
        else
            w_sum = {1'b0, (w_x[30:23] != 8'd0), w_x[22:0], 3'b000} - {1'b0, w_aligned};

        w_lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (w_sum[i]) w_lz = 5'(26 - i);
        end

        w_e = {2'b00, w_ex};
        w_l = 10'd0;
        if (w_sum[27]) begin
            w_e = w_e + 10'd1;
            w_m = w_sum[27:1] | {26'd0, w_sum[0]};
        end else begin
            // Left shift stops at exponent 1 so tiny results become subnormal.
            w_l = ({5'd0, w_lz} < (w_e - 10'd1)) ? {5'd0, w_lz} : (w_e - 10'd1);
            w_m = w_sum[26:0] << w_l;
            w_e = w_e - w_l;
        end

        w_rnd = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
        w_mr  = {1'b0, w_m[26:3]} + {24'd0, w_rnd};
        // Exponent field is 0 when no hidden bit survives (subnormal result).
        w_ef  = w_mr[24] ? (w_e + 10'd1) : (w_mr[23] ? w_e : 10'd0);

        if (is_nan(a) || is_nan(b))
            s = QNAN;
        else if (is_inf(a) && is_inf(b) && (a[31] != b[31]))
            s = QNAN;
        else if (is_inf(a))
            s = a;
        else if (is_inf(b))
            s = b;
        else if (w_sum == 28'd0)
            s = {w_same & w_x[31], 31'd0};
        else if (w_ef >= 10'd255)
            s = {w_x[31], 8'hFF, 23'd0};
        else
            s = {w_x[31], w_ef[7:0], (w_mr[24] ? 23'd0 : w_mr[22:0])};
    end

endmodule : fp_adder
`default_nettype wire

// File: rtl/fp_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : fp_accumulator
//  Purpose  : Streaming binary32 packet summer. Elements arrive on a
//             valid/ready stream delimited by in_last; one sum per packet is
//             emitted with a saturating element count and NaN/Inf flags.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             in_valid/in_ready/in_data/in_last - element stream
//             out_valid/out_ready/out_data      - packet sum stream
//             out_count, out_nan, out_inf       - sum sideband
//  Revision : 1.0  initial release
// ============================================================================
module fp_accumulator
    import fp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_nan,
    output logic             out_inf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic [FP_W-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [FP_W-1:0]   out_data_q,  out_data_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_nan_q,   out_nan_d;
    logic              out_inf_q,   out_inf_d;

    logic              w_accept;
    logic [FP_W-1:0]   w_sum;
    logic [FP_W-1:0]   w_res;
    logic [CNT_W-1:0]  w_cnt_inc;

    fp_adder u_fp_adder (
        .a (acc_q),
        .b (in_data),
        .s (w_sum)
    );

    assign in_ready  = (state_q != S_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_cnt_inc = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(1));
    // A single-element packet bypasses the adder so -0 and NaN payloads survive.
    assign w_res     = (state_q == S_IDLE) ? in_data : w_sum;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_nan_d   = out_nan_q;
        out_inf_d   = out_inf_q;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (w_accept) begin
                    if (in_last) begin
                        out_data_d  = w_res;
                        out_count_d = (state_q == S_IDLE) ? CNT_W'(1) : w_cnt_inc;
                        out_nan_d   = is_nan(w_res);
                        out_inf_d   = is_inf(w_res);
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        acc_d   = w_res;
                        cnt_d   = (state_q == S_IDLE) ? CNT_W'(1) : w_cnt_inc;
                        state_d = S_ACCUM;
                    end
                end
            end
            S_DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_nan_q   <= 1'b0;
            out_inf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_nan_q   <= out_nan_d;
            out_inf_q   <= out_inf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_nan   = out_nan_q;
    assign out_inf   = out_inf_q;

endmodule : fp_accumulator
`default_nettype wire

// File: tb/tb_fp_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_accumulator
//  Purpose  : Directed self-checking bench for fp_accumulator. Two instances
//             share one stimulus stream: CNT_W=16 and CNT_W=2 (saturation).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        out_nan;
    logic        out_inf;

    logic        in_ready2;
    logic        out_valid2;
    logic [31:0] out_data2;
    logic [1:0]  out_count2;
    logic        out_nan2;
    logic        out_inf2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int c0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_accumulator #(.CNT_W(16)) u_dut (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data), .in_last (in_last),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .out_count (out_count), .out_nan (out_nan), .out_inf (out_inf)
    );

    fp_accumulator #(.CNT_W(2)) u_dut_sat (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready2), .in_data (in_data), .in_last (in_last),
        .out_valid (out_valid2), .out_ready (out_ready), .out_data (out_data2),
        .out_count (out_count2), .out_nan (out_nan2), .out_inf (out_inf2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Called a little after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [31:0] d, input logic l);
        int budget;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        budget   = 0;
        while (!in_ready && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 50) check_eq("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #12;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_data",  out_data, 32'h0);
        check_eq("rst_out_count", {16'd0, out_count}, 32'd0);
        check_eq("rst_flags",     {30'd0, out_nan, out_inf}, 32'd0);
        rst_n = 1'b1;
        step();
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // in_last without in_valid must be ignored
        in_last = 1'b1; in_data = 32'h4000_0000;
        step(); step();
        in_last = 1'b0;
        check_eq("last_no_valid", {31'd0, out_valid}, 32'd0);

        // 1 + 2 + 3 = 6, full rate, one bubble
        c0 = cyc;
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        send(32'h4040_0000, 1'b1);
        check_eq("p1_cycles",    cyc - c0, 32'd3);
        check_eq("p1_valid",     {31'd0, out_valid}, 32'd1);
        check_eq("p1_data",      out_data, 32'h40C0_0000);
        check_eq("p1_count",     {16'd0, out_count}, 32'd3);
        check_eq("p1_flags",     {30'd0, out_nan, out_inf}, 32'd0);
        check_eq("p1_bubble",    {31'd0, in_ready}, 32'd0);
        step();
        check_eq("p1_drained",   {31'd0, out_valid}, 32'd0);
        check_eq("p1_ready",     {31'd0, in_ready}, 32'd1);

        // -0 single element, adder bypassed
        send(32'h8000_0000, 1'b1);
        check_eq("neg0_data",    out_data, 32'h8000_0000);
        check_eq("neg0_count",   {16'd0, out_count}, 32'd1);
        step();

        // 1 + -1 with output back-pressure
        out_ready = 1'b0;
        send(32'h3F80_0000, 1'b0);
        send(32'hBF80_0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid",    {31'd0, out_valid}, 32'd1);
            check_eq("bp_data",     out_data, 32'h0000_0000);
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check_eq("bp_released",  {31'd0, out_valid}, 32'd0);
        check_eq("bp_ready",     {31'd0, in_ready}, 32'd1);

        // inf + 1 + qNaN -> NaN
        send(32'h7F80_0000, 1'b0);
        send(32'h3F80_0000, 1'b0);
        send(32'h7FC0_0000, 1'b1);
        check_eq("nan_flags",    {30'd0, out_nan, out_inf}, 32'd2);
        check_eq("nan_data",     out_data, 32'h7FC0_0000);
        step();

        // inf + inf -> inf
        send(32'h7F80_0000, 1'b0);
        send(32'h7F80_0000, 1'b1);
        check_eq("inf_flags",    {30'd0, out_nan, out_inf}, 32'd1);
        check_eq("inf_data",     out_data, 32'h7F80_0000);
        step();

        // six ones: count saturates at 3 in the narrow instance
        for (int i = 0; i < 6; i++) send(32'h3F80_0000, (i == 5));
        check_eq("sat_count",    {30'd0, out_count2}, 32'd3);
        check_eq("sat_data",     out_data2, 32'h40C0_0000);
        check_eq("wide_count",   {16'd0, out_count}, 32'd6);
        check_eq("wide_data",    out_data, 32'h40C0_0000);
        step();

        // reset mid-packet discards the partial sum
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        rst_n = 1'b0;
        #2;
        check_eq("midrst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_ready", {31'd0, in_ready}, 32'd1);
        #2;
        rst_n = 1'b1;
        send(32'h4000_0000, 1'b1);
        check_eq("post_rst_data",  out_data, 32'h4000_0000);
        check_eq("post_rst_count", {16'd0, out_count}, 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fp_accumulator
`default_nettype wire
